cgra_instr_table_loader: RTL and testbench

Parametrised multi-column CGRA instruction store.
- Loads one column's instruction table at a time from HBM over an AXI4 read-only master.
- Packs AXI_DATA_WIDTH/INSTR_WIDTH instructions per beat, split into 4 KB-safe bursts.
- Exposes a per-column program counter (PC) and a registered instruction output to the CGRA columns.
- Next generation of the two-column runtime load table: adds width, depth and column generalisation, lane packing, multi-burst transfers, error reporting and PC end-wrap.

---
 rtl/cgra_instr_table_loader.sv | 213 +++++++++++++++++++++
 tb/tb_cgra_instr_table_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_instr_table_loader.sv
// Multi-column CGRA instruction store: loads one column's table at a time over an AXI4 read master.
// Optional build macro CGRA_PC_WRAP_EN: PC increment wraps to 0 at the column's last loaded entry.
module cgra_instr_table_loader #(
    parameter int NUM_COL        = 2,
    parameter int INSTR_WIDTH    = 32,
    parameter int DEPTH          = 4096,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int MAX_BURST      = 64,
    parameter int CYC_W          = 32,
    localparam int PC_W          = $clog2(DEPTH),
    localparam int COL_W         = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           ctrl_start,
    input  logic [COL_W-1:0]               ctrl_col,
    input  logic [AXI_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [AXI_ADDR_WIDTH-1:0]      ctrl_xfer_size_in_bytes,
    output logic                           ctrl_busy,
    output logic                           ctrl_done,
    output logic                           ctrl_err,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]      m_axi_rdata,
    input  logic                           m_axi_rlast,
    input  logic [NUM_COL-1:0]             clken_PC,
    input  logic [NUM_COL-1:0]             load_PC,
    input  logic [NUM_COL-1:0]             incr_PC,
    input  logic [NUM_COL*PC_W-1:0]        load_value_PC,
    output logic [NUM_COL*PC_W-1:0]        PC,
    output logic [NUM_COL*INSTR_WIDTH-1:0] instr,
    output logic [NUM_COL-1:0]             instr_valid,
    output logic [CYC_W-1:0]               cycle_register
);

    localparam int LANES       = AXI_DATA_WIDTH / INSTR_WIDTH;
    localparam int BEAT_SHIFT  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int INSTR_SHIFT = $clog2(INSTR_WIDTH / 8);
    localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A = AXI_ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
    state_t state, state_next;

    logic [COL_W-1:0]          col_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ADDR_WIDTH-1:0] beats_left;
    logic [AXI_ADDR_WIDTH-1:0] n_instr;
    logic [AXI_ADDR_WIDTH-1:0] wptr;
    logic [8:0]                burst_cnt;
    logic [8:0]                burst;
    logic [12:0]               to_4k;
    logic                      burst_last;
    logic                      beat_acc;
    logic [LANES-1:0]          lane_we;
    logic [PC_W-1:0]           last_entry [NUM_COL];

    assign burst_last = (burst_cnt == 9'd1);
    assign beat_acc   = (state == DATA) && m_axi_rvalid;
    assign ctrl_busy  = (state != IDLE);

    // Burst length: remaining beats, capped by MAX_BURST and by the next 4 KB boundary.
    always_comb begin
        to_4k = (13'h1000 - {1'b0, addr_q[11:0]}) >> BEAT_SHIFT;
        burst = (beats_left > AXI_ADDR_WIDTH'(MAX_BURST)) ? 9'(MAX_BURST) : beats_left[8:0];
        if (13'(burst) > to_4k) burst = to_4k[8:0];
    end

    assign m_axi_araddr = (state == ADDR) ? addr_q : '0;
    assign m_axi_arlen  = (state == ADDR) ? 8'(burst - 9'd1) : '0;

    always_comb begin
        lane_we = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_we[k] = ((wptr + AXI_ADDR_WIDTH'(k)) < n_instr) &&
                         ((wptr + AXI_ADDR_WIDTH'(k)) < DEPTH_A);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        ctrl_done     = 1'b0;
        case (state)
            IDLE: if (ctrl_start)
                      state_next = (ctrl_xfer_size_in_bytes == '0) ? DONE : ADDR;
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_next = DATA;
            end
            DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && burst_last)
                    state_next = (beats_left != '0) ? ADDR : DONE;
            end
            DONE: begin
                ctrl_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            col_q          <= '0;
            addr_q         <= '0;
            beats_left     <= '0;
            n_instr        <= '0;
            wptr           <= '0;
            burst_cnt      <= '0;
            ctrl_err       <= 1'b0;
            instr_valid    <= '0;
            cycle_register <= '0;
            for (int unsigned c = 0; c < NUM_COL; c++) last_entry[c] <= PC_W'(DEPTH - 1);
        end else begin
            case (state)
                IDLE: if (ctrl_start) begin
                    col_q      <= ctrl_col;
                    addr_q     <= ctrl_addr_offset;
                    beats_left <= (ctrl_xfer_size_in_bytes >> BEAT_SHIFT) +
                                  AXI_ADDR_WIDTH'(|ctrl_xfer_size_in_bytes[BEAT_SHIFT-1:0]);
                    n_instr    <= ctrl_xfer_size_in_bytes >> INSTR_SHIFT;
                    wptr       <= '0;
                    ctrl_err   <= 1'b0;
                    for (int unsigned c = 0; c < NUM_COL; c++)
                        if (ctrl_col == COL_W'(c)) instr_valid[c] <= 1'b0;
                end
                ADDR: if (m_axi_arready) begin
                    addr_q     <= addr_q + (AXI_ADDR_WIDTH'(burst) << BEAT_SHIFT);
                    beats_left <= beats_left - AXI_ADDR_WIDTH'(burst);
                    burst_cnt  <= burst;
                end
                DATA: if (m_axi_rvalid) begin
                    wptr      <= wptr + AXI_ADDR_WIDTH'(LANES);
                    burst_cnt <= burst_cnt - 9'd1;
                    // The beat count is authoritative; a misplaced rlast is only reported.
                    if (m_axi_rlast != burst_last) ctrl_err <= 1'b1;
                end
                DONE: begin
                    if (n_instr > DEPTH_A) ctrl_err <= 1'b1;
                    if (n_instr != '0) begin
                        for (int unsigned c = 0; c < NUM_COL; c++) begin
                            if (col_q == COL_W'(c)) begin
                                instr_valid[c] <= 1'b1;
                                last_entry[c]  <= (n_instr >= DEPTH_A) ? PC_W'(DEPTH - 1)
                                                                       : n_instr[PC_W-1:0] - PC_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase

            if (state == DONE)
                cycle_register <= '0;
            else if ((|clken_PC) && !(&cycle_register))
                cycle_register <= cycle_register + CYC_W'(1);
        end
    end

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        logic [INSTR_WIDTH-1:0] mem [DEPTH];
        logic [PC_W-1:0]        pc_q;
        logic [INSTR_WIDTH-1:0] instr_q;

        always_ff @(posedge aclk) begin
            if (beat_acc && (col_q == COL_W'(c))) begin
                for (int unsigned k = 0; k < LANES; k++)
                    if (lane_we[k])
                        mem[wptr[PC_W-1:0] + PC_W'(k)] <= m_axi_rdata[k*INSTR_WIDTH +: INSTR_WIDTH];
            end
        end

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                pc_q    <= '0;
                instr_q <= '0;
            end else if (clken_PC[c]) begin
                instr_q <= mem[pc_q];
                if (load_PC[c]) begin
                    pc_q <= load_value_PC[c*PC_W +: PC_W];
                end else if (incr_PC[c]) begin
`ifdef CGRA_PC_WRAP_EN
                    pc_q <= (pc_q == last_entry[c]) ? '0 : pc_q + PC_W'(1);
`else
                    pc_q <= pc_q + PC_W'(1);
`endif
                end
            end
        end

`ifndef CGRA_PC_WRAP_EN
        // last_entry is maintained as status but has no consumer without PC wrapping.
        logic unused_last_entry;
        assign unused_last_entry = ^last_entry[c];
`endif

        assign PC[c*PC_W +: PC_W]                   = pc_q;
        assign instr[c*INSTR_WIDTH +: INSTR_WIDTH] = instr_q;
    end

endmodule

// File: tb/tb_cgra_instr_table_loader.sv
// Self-checking bench for cgra_instr_table_loader: directed loads plus random loads against a table model.
`timescale 1ns/1ps
module tb_cgra_instr_table_loader;

    localparam int NUM_COL = 2;
    localparam int IW      = 32;
    localparam int DEPTH   = 4096;
    localparam int AW      = 64;
    localparam int DW      = 512;
    localparam int MAXB    = 64;
    localparam int CYC_W   = 32;
    localparam int PC_W    = 12;
    localparam int LANES   = DW / IW;
    localparam int BB      = DW / 8;

    logic                    aclk = 1'b0;
    logic                    areset;
    logic                    ctrl_start;
    logic [0:0]              ctrl_col;
    logic [AW-1:0]           ctrl_addr_offset;
    logic [AW-1:0]           ctrl_xfer_size_in_bytes;
    logic                    ctrl_busy, ctrl_done, ctrl_err;
    logic                    m_axi_arvalid, m_axi_arready;
    logic [AW-1:0]           m_axi_araddr;
    logic [7:0]              m_axi_arlen;
    logic                    m_axi_rvalid, m_axi_rready;
    logic [DW-1:0]           m_axi_rdata;
    logic                    m_axi_rlast;
    logic [NUM_COL-1:0]      clken_PC, load_PC, incr_PC;
    logic [NUM_COL*PC_W-1:0] load_value_PC, PC;
    logic [NUM_COL*IW-1:0]   instr;
    logic [NUM_COL-1:0]      instr_valid;
    logic [CYC_W-1:0]        cycle_register;

    always #5 aclk = ~aclk;

    cgra_instr_table_loader #(
        .NUM_COL(NUM_COL), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW), .MAX_BURST(MAXB), .CYC_W(CYC_W)
    ) dut (
        .aclk(aclk), .areset(areset),
        .ctrl_start(ctrl_start), .ctrl_col(ctrl_col), .ctrl_addr_offset(ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
        .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_err(ctrl_err),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .clken_PC(clken_PC), .load_PC(load_PC), .incr_PC(incr_PC),
        .load_value_PC(load_value_PC), .PC(PC), .instr(instr),
        .instr_valid(instr_valid), .cycle_register(cycle_register)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what each table entry should hold, and whether it was ever written.
    logic [IW-1:0]      tab   [NUM_COL][DEPTH];
    bit                 known [NUM_COL][DEPTH];
    int                 last_m [NUM_COL];
    logic [NUM_COL-1:0] valid_m;
    int                 cyc_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int c, input int p);
`ifdef CGRA_PC_WRAP_EN
        if (p == last_m[c]) return 0;
`endif
        return (p + 1) % DEPTH;
    endfunction

    task automatic step();
        if (|clken_PC) cyc_exp++;
        @(negedge aclk);
    endtask

    task automatic model_reset();
        valid_m = '0;
        cyc_exp = 0;
        for (int c = 0; c < NUM_COL; c++) last_m[c] = DEPTH - 1;
    endtask

    // One complete load; bad_rlast >= 0 puts rlast on that global beat only; abort_at >= 0 resets there.
    task automatic do_load(input int col, input longint unsigned addr, input longint unsigned bytes,
                           input int bad_rlast, input int abort_at);
        longint unsigned rem, len, a, n_instr, to4k;
        int bidx, n;
        bit exp_err;
        logic [DW-1:0] d;
        rem     = (bytes + BB - 1) / BB;
        n_instr = bytes / (IW / 8);
        exp_err = (n_instr > DEPTH) || (bad_rlast >= 0);
        ctrl_col = 1'(col);
        ctrl_addr_offset = addr;
        ctrl_xfer_size_in_bytes = bytes;
        ctrl_start = 1'b1;
        @(negedge aclk);
        ctrl_start = 1'b0;
        valid_m[col] = 1'b0;
        chk("busy_after_start", 64'(ctrl_busy), 64'(1));
        chk("err_cleared_on_start", 64'(ctrl_err), 64'(0));
        chk("valid_cleared_on_start", 64'(instr_valid), 64'(valid_m));
        a = addr;
        bidx = 0;
        while (rem > 0) begin
            to4k = (4096 - (a % 4096)) / BB;
            len = rem;
            if (len > MAXB) len = MAXB;
            if (len > to4k) len = to4k;
            n = 0;
            while (!m_axi_arvalid && n < 200) begin
                @(negedge aclk);
                n++;
            end
            chk("arvalid", 64'(m_axi_arvalid), 64'(1));
            chk("araddr", m_axi_araddr, a);
            chk("arlen", 64'(m_axi_arlen), len - 1);
            repeat ($urandom_range(0, 2)) @(negedge aclk);
            chk("arlen_stable", 64'(m_axi_arlen), len - 1);
            m_axi_arready = 1'b1;
            @(negedge aclk);
            m_axi_arready = 1'b0;
            for (longint unsigned i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 1)) @(negedge aclk);
                for (int w = 0; w < LANES; w++) d[w*IW +: IW] = $urandom;
                m_axi_rdata  = d;
                m_axi_rvalid = 1'b1;
                m_axi_rlast  = (bad_rlast >= 0) ? (bidx == bad_rlast) : (i == len - 1);
                if (bidx == abort_at) begin
                    areset = 1'b1;
                    #1;
                    chk("abort_arvalid", 64'(m_axi_arvalid), 64'(0));
                    chk("abort_rready", 64'(m_axi_rready), 64'(0));
                    chk("abort_busy", 64'(ctrl_busy), 64'(0));
                    chk("abort_pc", 64'(PC), 64'(0));
                    @(negedge aclk);
                    areset = 1'b0;
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    model_reset();
                    @(negedge aclk);
                    chk("abort_idle", 64'(ctrl_busy), 64'(0));
                    chk("abort_done_low", 64'(ctrl_done), 64'(0));
                    chk("abort_valid", 64'(instr_valid), 64'(0));
                    return;
                end
                chk("rready", 64'(m_axi_rready), 64'(1));
                @(negedge aclk);
                for (int k = 0; k < LANES; k++) begin
                    longint unsigned idx;
                    idx = longint'(bidx) * LANES + k;
                    if (idx < n_instr && idx < DEPTH) begin
                        tab[col][idx]   = d[k*IW +: IW];
                        known[col][idx] = 1'b1;
                    end
                end
                bidx++;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
            end
            rem -= len;
            a   += len * BB;
        end
        chk("done_pulse", 64'(ctrl_done), 64'(1));
        chk("busy_in_done", 64'(ctrl_busy), 64'(1));
        @(negedge aclk);
        if (n_instr > 0) begin
            valid_m[col] = 1'b1;
            last_m[col]  = (n_instr >= DEPTH) ? DEPTH - 1 : int'(n_instr) - 1;
        end
        cyc_exp = 0;
        chk("done_one_cycle", 64'(ctrl_done), 64'(0));
        chk("busy_after_done", 64'(ctrl_busy), 64'(0));
        chk("instr_valid", 64'(instr_valid), 64'(valid_m));
        chk("ctrl_err", 64'(ctrl_err), 64'(exp_err));
        chk("cycle_cleared", 64'(cycle_register), 64'(0));
    endtask

    // Load PCs of the masked columns, then increment; instr must follow the pre-edge PC.
    task automatic pc_walk(input logic [1:0] mask, input int s0, input int s1, input int steps);
        int pcm [NUM_COL];
        int prev [NUM_COL];
        pcm[0] = s0;
        pcm[1] = s1;
        clken_PC = mask;
        load_PC  = mask;
        incr_PC  = '0;
        load_value_PC = {PC_W'(s1), PC_W'(s0)};
        step();
        for (int c = 0; c < NUM_COL; c++)
            if (mask[c]) chk("pc_load", 64'(PC[c*PC_W +: PC_W]), 64'(pcm[c]));
        load_PC = '0;
        incr_PC = mask;
        for (int s = 0; s < steps; s++) begin
            prev = pcm;
            step();
            for (int c = 0; c < NUM_COL; c++) begin
                if (mask[c]) begin
                    pcm[c] = nxt(c, pcm[c]);
                    chk("pc_incr", 64'(PC[c*PC_W +: PC_W]), 64'(pcm[c]));
                    if (known[c][prev[c]])
                        chk("instr", 64'(instr[c*IW +: IW]), 64'(tab[c][prev[c]]));
                end
            end
        end
        clken_PC = '0;
        incr_PC  = '0;
        chk("cycle_register", 64'(cycle_register), 64'(cyc_exp));
    endtask

    initial begin
        int col, start, n;
        longint unsigned addr, bytes;
        logic [NUM_COL*PC_W-1:0] pc_before;
        logic [NUM_COL*IW-1:0]   instr_before;
        areset = 1'b1;
        ctrl_start = 1'b0;
        ctrl_col = '0;
        ctrl_addr_offset = '0;
        ctrl_xfer_size_in_bytes = '0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rdata = '0;
        m_axi_rlast = 1'b0;
        clken_PC = '0;
        load_PC = '0;
        incr_PC = '0;
        load_value_PC = '0;
        model_reset();
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        chk("rst_busy", 64'(ctrl_busy), 64'(0));
        chk("rst_done", 64'(ctrl_done), 64'(0));
        chk("rst_err", 64'(ctrl_err), 64'(0));
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
        chk("rst_rready", 64'(m_axi_rready), 64'(0));
        chk("rst_pc", 64'(PC), 64'(0));
        chk("rst_instr", instr, 64'(0));
        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_cycle", 64'(cycle_register), 64'(0));

        do_load(0, 64'h0, 64'hFF, -1, -1);
        do_load(1, 64'h40, 64'h100, -1, -1);
        pc_walk(2'b11, 0, 0, 4);

        do_load(0, 64'hF80, 64'h2000, -1, -1);
        pc_walk(2'b01, 2040, 0, 10);

        do_load(1, 64'h0, 64'h100, 1, -1);
        do_load(1, 64'h0, 64'h4040, -1, -1);
        pc_walk(2'b10, 0, 4093, 4);

        do_load(1, 64'h1000, 64'h0, -1, -1);
        chk("zero_size_keeps_col0", 64'(instr_valid[0]), 64'(1));

        do_load(0, 64'h80, 64'd12, -1, -1);
        pc_walk(2'b01, 0, 0, 4);

        do_load(0, 64'h100, 64'h100, -1, 2);
        do_load(0, 64'h200, 64'h80, -1, -1);
        pc_walk(2'b11, 0, 28, 6);

        for (int r = 0; r < 5; r++) begin
            col   = $urandom_range(0, 1);
            addr  = longint'($urandom_range(0, 200)) * BB;
            bytes = $urandom_range(1, 1500);
            do_load(col, addr, bytes, -1, -1);
            n = int'(bytes / 4);
            start = (n > 0) ? $urandom_range(0, n - 1) : 0;
            pc_walk(2'b11, (col == 0) ? start : $urandom_range(0, 40),
                           (col == 1) ? start : $urandom_range(0, 40), 6);
        end

        pc_before    = PC;
        instr_before = instr;
        incr_PC = 2'b11;
        step();
        step();
        incr_PC = '0;
        chk("hold_pc", 64'(PC), 64'(pc_before));
        chk("hold_instr", instr, instr_before);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
